// File: rtl/dma_tcq_arb.sv
// Shared PCIe write TCQ arbiter: grants requesters, allocates tags, routes completions.
// Build option DMA_TCQ_ARB_STRICT_PRIO_EN selects fixed priority instead of round-robin.
module dma_tcq_arb #(
  parameter int NREQ              = 4,
  parameter int BUFFER_SIZE_BITS  = 16,
  parameter int BUFFER_BURST_BITS = 6,
  parameter int REMOTE_ADDR_WIDTH = 32,
  parameter int MEM_TAG           = 5,
  parameter int DATA_BITS         = 4,
  parameter int MAX_OUTST         = 4,
  localparam int LW   = BUFFER_SIZE_BITS - DATA_BITS,
  localparam int RW   = REMOTE_ADDR_WIDTH - DATA_BITS,
  localparam int LENW = BUFFER_BURST_BITS + 3 - DATA_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         s_tcq_valid,
  output logic [NREQ-1:0]         s_tcq_ready,
  input  logic [NREQ*LW-1:0]      s_tcq_laddr,
  input  logic [NREQ*RW-1:0]      s_tcq_raddr,
  input  logic [NREQ*LENW-1:0]    s_tcq_length,
  output logic [NREQ-1:0]         s_tcq_cvalid,
  output logic [NREQ*MEM_TAG-1:0] outst_cnt,
  output logic                    m_tcq_valid,
  input  logic                    m_tcq_ready,
  output logic [LW-1:0]           m_tcq_laddr,
  output logic [RW-1:0]           m_tcq_raddr,
  output logic [LENW-1:0]         m_tcq_length,
  output logic [MEM_TAG-1:0]      m_tcq_tag,
  input  logic                    m_tcq_cvalid,
  output logic                    m_tcq_cready,
  input  logic [MEM_TAG-1:0]      m_tcq_ctag,
  output logic                    err_tag
);
  localparam int NTAG = 1 << MEM_TAG;
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [MEM_TAG-1:0] MAXC = MEM_TAG'(MAX_OUTST);

  logic                m_valid_q, m_valid_d;
  logic [LW-1:0]       m_laddr_q;
  logic [RW-1:0]       m_raddr_q;
  logic [LENW-1:0]     m_len_q;
  logic [MEM_TAG-1:0]  m_tag_q;
  logic [NTAG-1:0]     busy_q, busy_d;
  logic [IW-1:0]       owner_q [NTAG];
  logic [MEM_TAG-1:0]  cnt_q [NREQ];
  logic [MEM_TAG-1:0]  cnt_d [NREQ];
  logic [NREQ-1:0]     cvalid_q, cvalid_d;
  logic                err_q, err_d;

  logic [NREQ-1:0]     elig;
  logic                any_free, can_load, hit, grant;
  logic [MEM_TAG-1:0]  free_tag;
  logic [IW-1:0]       sel;
  logic                c_busy;
  logic [IW-1:0]       c_own;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = s_tcq_valid[i] && (cnt_q[i] < MAXC);
    end
  end

  // lowest-index free tag wins
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    for (int t = NTAG - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        any_free = 1'b1;
        free_tag = MEM_TAG'(t);
      end
    end
  end

`ifdef DMA_TCQ_ARB_STRICT_PRIO_EN
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        hit = 1'b1;
        sel = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int j;
    hit = 1'b0;
    sel = '0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!hit && elig[j]) begin
        hit = 1'b1;
        sel = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign can_load    = (!m_valid_q || m_tcq_ready) && any_free;
  assign grant       = hit && can_load;
  assign s_tcq_ready = grant ? (NREQ'(1) << sel) : '0;

  assign c_busy = m_tcq_cvalid && busy_q[m_tcq_ctag];
  assign c_own  = owner_q[m_tcq_ctag];

  // a tag freed this cycle is not visible to free_tag until next cycle
  always_comb begin
    busy_d = busy_q;
    if (c_busy) busy_d[m_tcq_ctag] = 1'b0;
    if (grant)  busy_d[free_tag]   = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cvalid_d[i] = c_busy && (c_own == IW'(i));
      cnt_d[i]    = cnt_q[i];
      unique case ({grant && (sel == IW'(i)), cvalid_d[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + MEM_TAG'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - MEM_TAG'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign err_d     = err_q | (m_tcq_cvalid & ~busy_q[m_tcq_ctag]);
  assign m_valid_d = (!m_valid_q || m_tcq_ready) ? grant : m_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_laddr_q <= '0;
      m_raddr_q <= '0;
      m_len_q   <= '0;
      m_tag_q   <= '0;
      busy_q    <= '0;
      cvalid_q  <= '0;
      err_q     <= 1'b0;
      for (int t = 0; t < NTAG; t++) owner_q[t] <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      cvalid_q  <= cvalid_d;
      err_q     <= err_d;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      if (grant) begin
        m_laddr_q         <= s_tcq_laddr[int'(sel)*LW +: LW];
        m_raddr_q         <= s_tcq_raddr[int'(sel)*RW +: RW];
        m_len_q           <= s_tcq_length[int'(sel)*LENW +: LENW];
        m_tag_q           <= free_tag;
        owner_q[free_tag] <= sel;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      outst_cnt[i*MEM_TAG +: MEM_TAG] = cnt_q[i];
    end
  end

  assign m_tcq_valid  = m_valid_q;
  assign m_tcq_laddr  = m_laddr_q;
  assign m_tcq_raddr  = m_raddr_q;
  assign m_tcq_length = m_len_q;
  assign m_tcq_tag    = m_tag_q;
  assign m_tcq_cready = 1'b1;
  assign s_tcq_cvalid = cvalid_q;
  assign err_tag      = err_q;
endmodule

// File: tb/tb_dma_tcq_arb.sv
// Directed bench for dma_tcq_arb: RR grants, tag reuse, hold, exhaustion, errors.
// MAX_OUTST=9 so four requesters can drain the 32-tag pool.
module tb_dma_tcq_arb;
  localparam int NREQ = 4;
  localparam int MT   = 5;
  localparam int LW   = 12;
  localparam int RW   = 28;
  localparam int LENW = 5;
`ifdef DMA_TCQ_ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      s_tcq_valid;
  logic [NREQ-1:0]      s_tcq_ready;
  logic [NREQ*LW-1:0]   s_tcq_laddr;
  logic [NREQ*RW-1:0]   s_tcq_raddr;
  logic [NREQ*LENW-1:0] s_tcq_length;
  logic [NREQ-1:0]      s_tcq_cvalid;
  logic [NREQ*MT-1:0]   outst_cnt;
  logic                 m_tcq_valid;
  logic                 m_tcq_ready;
  logic [LW-1:0]        m_tcq_laddr;
  logic [RW-1:0]        m_tcq_raddr;
  logic [LENW-1:0]      m_tcq_length;
  logic [MT-1:0]        m_tcq_tag;
  logic                 m_tcq_cvalid;
  logic                 m_tcq_cready;
  logic [MT-1:0]        m_tcq_ctag;
  logic                 err_tag;

  int nvec = 0;
  int nerr = 0;

  dma_tcq_arb #(
    .NREQ(NREQ), .BUFFER_SIZE_BITS(16), .BUFFER_BURST_BITS(6),
    .REMOTE_ADDR_WIDTH(32), .MEM_TAG(MT), .DATA_BITS(4), .MAX_OUTST(9)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tcq_valid(s_tcq_valid), .s_tcq_ready(s_tcq_ready),
    .s_tcq_laddr(s_tcq_laddr), .s_tcq_raddr(s_tcq_raddr),
    .s_tcq_length(s_tcq_length), .s_tcq_cvalid(s_tcq_cvalid),
    .outst_cnt(outst_cnt),
    .m_tcq_valid(m_tcq_valid), .m_tcq_ready(m_tcq_ready),
    .m_tcq_laddr(m_tcq_laddr), .m_tcq_raddr(m_tcq_raddr),
    .m_tcq_length(m_tcq_length), .m_tcq_tag(m_tcq_tag),
    .m_tcq_cvalid(m_tcq_cvalid), .m_tcq_cready(m_tcq_cready),
    .m_tcq_ctag(m_tcq_ctag), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int c0, c1, c2, c3);
    return 64'((c3 << 15) | (c2 << 10) | (c1 << 5) | c0);
  endfunction

  initial begin
    int own [4];
    int cn [4];
    int e;
    rst = 1'b1;
    s_tcq_valid  = '0;
    m_tcq_ready  = 1'b0;
    m_tcq_cvalid = 1'b0;
    m_tcq_ctag   = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_tcq_laddr[i*LW +: LW]     = LW'(12'h100 + i);
      s_tcq_raddr[i*RW +: RW]     = RW'(28'h0ABC000 + i);
      s_tcq_length[i*LENW +: LENW] = LENW'(i + 1);
    end
    for (int i = 0; i < 4; i++) cn[i] = 0;
    tick();
    tick();
    chk("rst_mvalid", 64'(m_tcq_valid), 0);
    chk("rst_cvalid", 64'(s_tcq_cvalid), 0);
    chk("rst_err", 64'(err_tag), 0);
    chk("rst_outst", 64'(outst_cnt), 0);
    chk("rst_laddr", 64'(m_tcq_laddr), 0);
    chk("rst_tag", 64'(m_tcq_tag), 0);
    chk("cready", 64'(m_tcq_cready), 1);
    rst = 1'b0;
    tick();

    // alternating grants between requesters 0 and 2
    s_tcq_valid = 4'b0101;
    m_tcq_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = STRICT ? 0 : ((k % 2 == 1) ? 2 : 0);
      own[k] = e;
      cn[e]++;
      chk("alt_ready", 64'(s_tcq_ready), 64'(1 << e));
      tick();
      chk("alt_mvalid", 64'(m_tcq_valid), 1);
      chk("alt_tag", 64'(m_tcq_tag), 64'(k));
      chk("alt_laddr", 64'(m_tcq_laddr), 64'(256 + e));
    end
    s_tcq_valid = 4'b0000;
    #1;
    chk("alt_idle_ready", 64'(s_tcq_ready), 0);
    tick();
    chk("alt_drop", 64'(m_tcq_valid), 0);
    chk("alt_outst", 64'(outst_cnt), pk(cn[0], 0, cn[2], 0));
    for (int k = 0; k < 4; k++) begin
      m_tcq_cvalid = 1'b1;
      m_tcq_ctag   = MT'(k);
      tick();
      chk("cpl_route", 64'(s_tcq_cvalid), 64'(1 << own[k]));
    end
    m_tcq_cvalid = 1'b0;
    tick();
    chk("cpl_pulse_end", 64'(s_tcq_cvalid), 0);
    chk("cpl_outst0", 64'(outst_cnt), 0);

    // single requester fills MAX_OUTST
    s_tcq_valid = 4'b0001;
    #1;
    for (int k = 0; k < 9; k++) begin
      chk("max_ready", 64'(s_tcq_ready), 1);
      tick();
      chk("max_tag", 64'(m_tcq_tag), 64'(k));
    end
    chk("max_stop", 64'(s_tcq_ready), 0);
    tick();
    chk("max_drop", 64'(m_tcq_valid), 0);
    chk("max_outst", 64'(outst_cnt), pk(9, 0, 0, 0));
    m_tcq_cvalid = 1'b1;
    m_tcq_ctag   = 5'd1;
    tick();
    m_tcq_cvalid = 1'b0;
    #1;
    chk("reuse_cpl", 64'(s_tcq_cvalid), 1);
    chk("reuse_ready", 64'(s_tcq_ready), 1);
    chk("reuse_outst", 64'(outst_cnt), pk(8, 0, 0, 0));
    tick();
    chk("reuse_tag", 64'(m_tcq_tag), 1);
    chk("reuse_pulse1", 64'(s_tcq_cvalid), 0);
    s_tcq_valid = 4'b0000;
    tick();

    // completion for a tag that was never allocated
    m_tcq_cvalid = 1'b1;
    m_tcq_ctag   = 5'd9;
    tick();
    m_tcq_cvalid = 1'b0;
    #1;
    chk("err_set", 64'(err_tag), 1);
    chk("err_nopulse", 64'(s_tcq_cvalid), 0);
    chk("err_outst", 64'(outst_cnt), pk(9, 0, 0, 0));
    tick();
    chk("err_sticky", 64'(err_tag), 1);

    // downstream backpressure hold
    s_tcq_valid = 4'b0010;
    m_tcq_ready = 1'b0;
    #1;
    chk("hold_first", 64'(s_tcq_ready), 2);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", 64'(m_tcq_valid), 1);
      chk("hold_tag", 64'(m_tcq_tag), 9);
      chk("hold_laddr", 64'(m_tcq_laddr), 64'h101);
      chk("hold_ready", 64'(s_tcq_ready), 0);
    end
    chk("hold_raddr", 64'(m_tcq_raddr), 64'h0ABC001);
    chk("hold_len", 64'(m_tcq_length), 2);
    m_tcq_ready = 1'b1;
    #1;
    chk("hold_release", 64'(s_tcq_ready), 2);
    tick();
    chk("hold_next_tag", 64'(m_tcq_tag), 10);
    chk("hold_next_v", 64'(m_tcq_valid), 1);
    s_tcq_valid = 4'b0000;
    tick();
    chk("hold_drop", 64'(m_tcq_valid), 0);

    // grant and completion for the same requester together
    s_tcq_valid  = 4'b0010;
    m_tcq_cvalid = 1'b1;
    m_tcq_ctag   = 5'd9;
    #1;
    chk("same_ready", 64'(s_tcq_ready), 2);
    tick();
    s_tcq_valid  = 4'b0000;
    m_tcq_cvalid = 1'b0;
    #1;
    chk("same_tag", 64'(m_tcq_tag), 11);
    chk("same_cpl", 64'(s_tcq_cvalid), 2);
    chk("same_outst", 64'(outst_cnt), pk(9, 2, 0, 0));
    tick();

    // drain the tag pool
    s_tcq_valid = 4'b1110;
    #1;
    for (int k = 0; k < 21; k++) begin
      if (STRICT) e = (k < 7) ? 1 : ((k < 16) ? 2 : 3);
      else        e = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 3 : 1);
      chk("pool_ready", 64'(s_tcq_ready), 64'(1 << e));
      tick();
      chk("pool_tag", 64'(m_tcq_tag), (k == 0) ? 64'd9 : 64'(11 + k));
    end
    chk("pool_full", 64'(s_tcq_ready), 0);
    tick();
    chk("pool_drop", 64'(m_tcq_valid), 0);
    chk("pool_outst", 64'(outst_cnt),
        STRICT ? pk(9, 9, 9, 5) : pk(9, 9, 7, 7));
    m_tcq_cvalid = 1'b1;
    m_tcq_ctag   = 5'd7;
    tick();
    m_tcq_cvalid = 1'b0;
    #1;
    e = STRICT ? 3 : 2;
    chk("pool_cpl", 64'(s_tcq_cvalid), 1);
    chk("pool_regrant", 64'(s_tcq_ready), 64'(1 << e));
    tick();
    chk("pool_tag7", 64'(m_tcq_tag), 7);
    chk("pool_laddr", 64'(m_tcq_laddr), 64'(256 + e));
    s_tcq_valid = 4'b0000;

    // reset in the middle of traffic
    rst = 1'b1;
    #1;
    chk("mid_rst_v", 64'(m_tcq_valid), 0);
    chk("mid_rst_cnt", 64'(outst_cnt), 0);
    chk("mid_rst_err", 64'(err_tag), 0);
    tick();
    rst = 1'b0;
    m_tcq_cvalid = 1'b1;
    m_tcq_ctag   = 5'd3;
    tick();
    m_tcq_cvalid = 1'b0;
    #1;
    chk("stale_err", 64'(err_tag), 1);
    chk("stale_nopulse", 64'(s_tcq_cvalid), 0);

    // requesters 1 and 3 competing
    s_tcq_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      e = STRICT ? 1 : ((k % 2 == 1) ? 3 : 1);
      chk("pr_ready", 64'(s_tcq_ready), 64'(1 << e));
      tick();
      chk("pr_tag", 64'(m_tcq_tag), 64'(k));
    end
    s_tcq_valid = 4'b1000;
    #1;
    chk("pr_three", 64'(s_tcq_ready), 8);
    tick();
    s_tcq_valid = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
